// File: rtl/clint_ctrl.sv
// Core-local trap sequencer: stalls the pipeline, writes mstatus/mepc/mcause
// through a dedicated CSR port, then redirects the PC to mtvec or mepc.
module clint_ctrl #(
  parameter int          INT_WIDTH = 8,
  parameter logic [31:0] EXT_CAUSE = 32'h8000_0010
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst_i,
  input  logic [31:0]          inst_addr_i,
  input  logic                 jump_flag_i,
  input  logic [31:0]          jump_addr_i,
  input  logic                 div_busy_i,
  input  logic [INT_WIDTH-1:0] int_flag_i,
  input  logic                 global_int_en_i,
  input  logic [31:0]          csr_mtvec_i,
  input  logic [31:0]          csr_mepc_i,
  input  logic [31:0]          csr_mstatus_i,
  output logic                 hold_flag_o,
  output logic                 csr_wen_o,
  output logic [11:0]          csr_waddr_o,
  output logic [31:0]          csr_wdata_o,
  output logic                 int_jump_flag_o,
  output logic [31:0]          int_addr_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MSTATUS  = 3'd1;
  localparam logic [2:0] S_MEPC     = 3'd2;
  localparam logic [2:0] S_MCAUSE   = 3'd3;
  localparam logic [2:0] S_TRAP_JMP = 3'd4;
  localparam logic [2:0] S_MRET_ST  = 3'd5;
  localparam logic [2:0] S_RET_JMP  = 3'd6;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        trig_sync;
  logic        trig_mret;
  logic        trig_async;
  logic [31:0] irq_cause;

  assign trig_sync  = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
  assign trig_mret  = (inst_i == INST_MRET);
  assign trig_async = global_int_en_i && !div_busy_i && (|int_flag_i);

  // Scan from the top down so the lowest set line is the last assignment.
  always_comb begin
    irq_cause = EXT_CAUSE;
    for (int k = INT_WIDTH - 1; k >= 0; k--) begin
      if (int_flag_i[k]) irq_cause = EXT_CAUSE + 32'(k);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (trig_sync)       state_nxt = S_MSTATUS;
        else if (trig_mret)  state_nxt = S_MRET_ST;
        else if (trig_async) state_nxt = S_MSTATUS;
      end
      S_MSTATUS:  state_nxt = S_MEPC;
      S_MEPC:     state_nxt = S_MCAUSE;
      S_MCAUSE:   state_nxt = S_TRAP_JMP;
      S_TRAP_JMP: state_nxt = S_IDLE;
      S_MRET_ST:  state_nxt = S_RET_JMP;
      S_RET_JMP:  state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cause <= 32'd0;
      epc   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        if (trig_sync) begin
          cause <= (inst_i == INST_ECALL) ? 32'd11 : 32'd3;
          epc   <= inst_addr_i;
        end else if (!trig_mret && trig_async) begin
          // The ID instruction is squashed; resume at the pending jump target if any.
          cause <= irq_cause;
          epc   <= jump_flag_i ? jump_addr_i : inst_addr_i;
        end
      end
    end
  end

  // Stall is combinational on the detection cycle, gated so reset forces it low.
  assign hold_flag_o = rst && ((state != S_IDLE) || trig_sync || trig_mret || trig_async);

  always_comb begin
    csr_wen_o       = 1'b0;
    csr_waddr_o     = 12'd0;
    csr_wdata_o     = 32'd0;
    int_jump_flag_o = 1'b0;
    int_addr_o      = 32'd0;
    case (state)
      S_MSTATUS: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                       1'b0, csr_mstatus_i[2:0]};
      end
      S_MEPC: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc;
      end
      S_MCAUSE: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause;
      end
      S_TRAP_JMP: begin
        int_jump_flag_o = 1'b1;
        int_addr_o      = csr_mtvec_i & 32'hFFFF_FFFC;
      end
      S_MRET_ST: begin
        csr_wen_o   = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                       csr_mstatus_i[7], csr_mstatus_i[2:0]};
      end
      S_RET_JMP: begin
        int_jump_flag_o = 1'b1;
        int_addr_o      = csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Directed bench for clint_ctrl: trap, interrupt, mret and reset sequences.
module tb_clint_ctrl;

  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        div_busy_i;
  logic [7:0]  int_flag_i;
  logic        global_int_en_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        hold_flag_o;
  logic        csr_wen_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        int_jump_flag_o;
  logic [31:0] int_addr_o;

  int checks = 0;
  int errors = 0;

  clint_ctrl #(.INT_WIDTH(8), .EXT_CAUSE(32'h8000_0010)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .div_busy_i(div_busy_i),
    .int_flag_i(int_flag_i), .global_int_en_i(global_int_en_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o(hold_flag_o), .csr_wen_o(csr_wen_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .int_jump_flag_o(int_jump_flag_o), .int_addr_o(int_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against one expected vector.
  task automatic chk_all(input string tag, input logic h, input logic w,
                         input logic [11:0] wa, input logic [31:0] wd,
                         input logic j, input logic [31:0] ja);
    chk({tag, ".hold"},  32'(hold_flag_o),     32'(h));
    chk({tag, ".wen"},   32'(csr_wen_o),       32'(w));
    chk({tag, ".waddr"}, 32'(csr_waddr_o),     32'(wa));
    chk({tag, ".wdata"}, csr_wdata_o,          wd);
    chk({tag, ".jump"},  32'(int_jump_flag_o), 32'(j));
    chk({tag, ".jaddr"}, int_addr_o,           ja);
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; inst_i = NOP; inst_addr_i = 32'h0; jump_flag_i = 1'b0;
    jump_addr_i = 32'h0; div_busy_i = 1'b0; int_flag_i = 8'h0; global_int_en_i = 1'b0;
    csr_mtvec_i = 32'h201; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;
    tick(); #1;
    chk_all("reset", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    rst = 1'b1;

    // 1: ecall, mtvec low bits must be masked off
    tick();
    global_int_en_i = 1'b1; inst_i = ECALL; inst_addr_i = 32'h100; #1;
    chk_all("t1.T0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    tick(); inst_i = NOP; global_int_en_i = 1'b0; #1;
    chk_all("t1.T1", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    tick(); #1; chk_all("t1.T2", 1, 1, 12'h341, 32'h100, 0, 32'h0);
    tick(); #1; chk_all("t1.T3", 1, 1, 12'h342, 32'd11, 0, 32'h0);
    tick(); #1; chk_all("t1.T4", 1, 0, 12'h0, 32'h0, 1, 32'h200);
    tick(); #1; chk_all("t1.idle", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // 2: lines 1 and 2 pending, line 1 wins
    inst_addr_i = 32'h120; int_flag_i = 8'b0000_0110; global_int_en_i = 1'b1; #1;
    chk_all("t2.T0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    tick(); global_int_en_i = 1'b0; #1;
    chk_all("t2.T1", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    tick(); #1; chk_all("t2.T2", 1, 1, 12'h341, 32'h120, 0, 32'h0);
    tick(); #1; chk_all("t2.T3", 1, 1, 12'h342, 32'h8000_0011, 0, 32'h0);
    tick(); #1; chk_all("t2.T4", 1, 0, 12'h0, 32'h0, 1, 32'h200);
    tick(); #1; chk_all("t2.masked", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    int_flag_i = 8'h0;

    // 3a: irq while ex jumps, epc is the jump target
    tick();
    inst_addr_i = 32'h130; jump_flag_i = 1'b1; jump_addr_i = 32'h340;
    int_flag_i = 8'h01; global_int_en_i = 1'b1; #1;
    chk("t3a.T0.hold", 32'(hold_flag_o), 32'h1);
    tick(); global_int_en_i = 1'b0; jump_flag_i = 1'b0; int_flag_i = 8'h0; #1;
    chk("t3a.T1.wdata", csr_wdata_o, 32'h80);
    tick(); #1; chk_all("t3a.T2", 1, 1, 12'h341, 32'h340, 0, 32'h0);
    tick(); #1; chk_all("t3a.T3", 1, 1, 12'h342, 32'h8000_0010, 0, 32'h0);
    tick(); #1; chk("t3a.T4.jump", 32'(int_jump_flag_o), 32'h1);
    tick(); #1; chk("t3a.idle.hold", 32'(hold_flag_o), 32'h0);

    // 3b: divider busy defers the irq for 4 cycles
    inst_addr_i = 32'h140; int_flag_i = 8'h80; global_int_en_i = 1'b1; div_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("t3b.busy.hold", 32'(hold_flag_o), 32'h0);
      chk("t3b.busy.wen", 32'(csr_wen_o), 32'h0);
      tick();
    end
    div_busy_i = 1'b0; #1;
    chk("t3b.T0.hold", 32'(hold_flag_o), 32'h1);
    tick(); global_int_en_i = 1'b0; int_flag_i = 8'h0; #1;
    chk_all("t3b.T1", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    tick(); #1; chk_all("t3b.T2", 1, 1, 12'h341, 32'h140, 0, 32'h0);
    tick(); #1; chk_all("t3b.T3", 1, 1, 12'h342, 32'h8000_0017, 0, 32'h0);
    tick(); #1; chk_all("t3b.T4", 1, 0, 12'h0, 32'h0, 1, 32'h200);
    tick(); #1; chk("t3b.idle.hold", 32'(hold_flag_o), 32'h0);

    // 4: mret
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; inst_i = MRET; inst_addr_i = 32'h208; #1;
    chk_all("t4.T0", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    tick(); inst_i = NOP; #1;
    chk_all("t4.T1", 1, 1, 12'h300, 32'h88, 0, 32'h0);
    tick(); #1; chk_all("t4.T2", 1, 0, 12'h0, 32'h0, 1, 32'h104);
    tick(); #1; chk_all("t4.idle", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    // 5: ecall beats a pending irq; no follow-up trap once MIE is clear
    csr_mstatus_i = 32'h8; global_int_en_i = 1'b1; int_flag_i = 8'h04;
    inst_i = ECALL; inst_addr_i = 32'h150; #1;
    chk("t5.T0.hold", 32'(hold_flag_o), 32'h1);
    tick(); inst_i = NOP; global_int_en_i = 1'b0; #1;
    chk_all("t5.T1", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    tick(); #1; chk_all("t5.T2", 1, 1, 12'h341, 32'h150, 0, 32'h0);
    tick(); #1; chk_all("t5.T3", 1, 1, 12'h342, 32'd11, 0, 32'h0);
    tick(); #1; chk_all("t5.T4", 1, 0, 12'h0, 32'h0, 1, 32'h200);
    tick(); #1; chk_all("t5.idle", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    tick(); #1; chk("t5.idle2.hold", 32'(hold_flag_o), 32'h0);
    int_flag_i = 8'h0;

    // 6: reset at T2, then a fresh ecall restarts cleanly
    inst_i = ECALL; inst_addr_i = 32'h160; #1;
    chk("t6.T0.hold", 32'(hold_flag_o), 32'h1);
    tick(); #1; chk("t6.T1.wen", 32'(csr_wen_o), 32'h1);
    tick(); #1; chk_all("t6.T2", 1, 1, 12'h341, 32'h160, 0, 32'h0);
    rst = 1'b0; #1;
    chk_all("t6.rst", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    tick(); #1; chk_all("t6.rst2", 0, 0, 12'h0, 32'h0, 0, 32'h0);
    inst_addr_i = 32'h170; rst = 1'b1; #1;
    chk_all("t6.T0b", 1, 0, 12'h0, 32'h0, 0, 32'h0);
    tick(); inst_i = NOP; #1;
    chk_all("t6.T1b", 1, 1, 12'h300, 32'h80, 0, 32'h0);
    tick(); #1; chk_all("t6.T2b", 1, 1, 12'h341, 32'h170, 0, 32'h0);
    tick(); #1; chk_all("t6.T3b", 1, 1, 12'h342, 32'd11, 0, 32'h0);
    tick(); #1; chk_all("t6.T4b", 1, 0, 12'h0, 32'h0, 1, 32'h200);
    tick(); #1; chk_all("t6.idle", 0, 0, 12'h0, 32'h0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
